// File: rtl/usr_pkg.sv
// usr_pkg: shared mode and FSM encodings for the universal shift register
package usr_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_LOAD = 3'd1,
        MODE_SHL  = 3'd2,
        MODE_SHR  = 3'd3,
        MODE_ROL  = 3'd4,
        MODE_ROR  = 3'd5,
        MODE_CLR  = 3'd6,
        MODE_SET  = 3'd7
    } usr_mode_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } usr_state_t;

    function automatic logic is_shift_mode(input logic [2:0] m);
        return (m >= MODE_SHL) && (m <= MODE_ROR);
    endfunction

endpackage

// File: rtl/usr_shift_unit.sv
// usr_shift_unit: combinational one-step shift/rotate of q with the bit pushed out
module usr_shift_unit
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q_i,
    input  usr_mode_t        op_i,
    input  logic             sin_i,
    output logic [WIDTH-1:0] q_o,
    output logic             sout_o,
    output logic             shift_o
);

    // Non-shift ops pass q through and flag that sout must not change
    always_comb begin
        q_o     = q_i;
        sout_o  = 1'b0;
        shift_o = 1'b1;
        case (op_i)
            MODE_SHL: begin q_o = {q_i[WIDTH-2:0], sin_i};      sout_o = q_i[WIDTH-1]; end
            MODE_SHR: begin q_o = {sin_i, q_i[WIDTH-1:1]};      sout_o = q_i[0];       end
            MODE_ROL: begin q_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]}; sout_o = q_i[WIDTH-1]; end
            MODE_ROR: begin q_o = {q_i[0], q_i[WIDTH-1:1]};     sout_o = q_i[0];       end
            default:  shift_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: universal register with single-cycle ops and a counted shift/rotate burst engine
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int               AW      = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    input  logic             start,
    input  logic [AW-1:0]    amt,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    usr_state_t       state_q, state_d;
    usr_mode_t        op_q, op_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] reg_q, reg_d;
    logic             sout_q, sout_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] sh_q;
    logic             sh_sout, sh_valid;
    logic [AW-1:0]    amt_clamp;

    assign amt_clamp = (amt > AW'(WIDTH)) ? AW'(WIDTH) : amt;

    // One shifter serves both paths: during a burst the latched op drives it
    usr_shift_unit #(.WIDTH(WIDTH)) u_shift (
        .q_i    (reg_q),
        .op_i   ((state_q == S_RUN) ? op_q : usr_mode_t'(mode)),
        .sin_i  (sin),
        .q_o    (sh_q),
        .sout_o (sh_sout),
        .shift_o(sh_valid)
    );

    // Next-state: burst stepping, burst launch, or a single-cycle mode; done defaults low so it pulses once
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        reg_d   = reg_q;
        sout_d  = sout_q;
        done_d  = 1'b0;
        if (en) begin
            if (state_q == S_RUN) begin
                reg_d  = sh_q;
                sout_d = sh_sout;
                cnt_d  = cnt_q - AW'(1);
                if (cnt_q == AW'(1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end else if (start && is_shift_mode(mode)) begin
                op_d    = usr_mode_t'(mode);
                cnt_d   = amt_clamp;
                state_d = (amt_clamp == '0) ? S_IDLE : S_RUN;
                done_d  = (amt_clamp == '0);
            end else begin
                reg_d  = sh_valid ? sh_q :
                         (mode == MODE_LOAD) ? d :
                         (mode == MODE_CLR)  ? '0 :
                         (mode == MODE_SET)  ? '1 : reg_q;
                sout_d = sh_valid ? sh_sout : sout_q;
            end
        end
    end

    // State registers with asynchronous reset that also aborts any burst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= MODE_HOLD;
            cnt_q   <= '0;
            reg_q   <= RST_VAL;
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            reg_q   <= reg_d;
            sout_q  <= sout_d;
            done_q  <= done_d;
        end
    end

    assign q    = reg_q;
    assign sout = sout_q;
    assign busy = (state_q == S_RUN);
    assign done = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: directed and random checks of univ_shift_reg against an arithmetic reference model
module tb_univ_shift_reg;

    localparam int WIDTH = 8;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic [2:0]       mode = 3'd0;
    logic [WIDTH-1:0] d = '0;
    logic             sin = 1'b0;
    logic             start = 1'b0;
    logic [AW-1:0]    amt = '0;
    logic [WIDTH-1:0] q;
    logic             sout, busy, done;

    int n_checks = 0;
    int n_errors = 0;

    int m_q, m_sout, m_busy, m_done, m_cnt, m_op;

    univ_shift_reg #(.WIDTH(WIDTH), .RST_VAL(8'hA5)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .sin(sin),
        .start(start), .amt(amt), .q(q), .sout(sout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_model();
        check("q", int'(q), m_q);
        check("sout", int'(sout), m_sout);
        check("busy", int'(busy), m_busy);
        check("done", int'(done), m_done);
    endtask

    task automatic model_reset();
        m_q = 'hA5; m_sout = 0; m_busy = 0; m_done = 0; m_cnt = 0; m_op = 0;
    endtask

    task automatic model_apply(input int op);
        int s;
        s = int'(sin);
        case (op)
            2: begin m_sout = m_q / 128; m_q = (m_q * 2 + s) % 256;           end
            3: begin m_sout = m_q % 2;   m_q = m_q / 2 + s * 128;             end
            4: begin m_sout = m_q / 128; m_q = (m_q * 2) % 256 + m_q / 128;   end
            5: begin m_sout = m_q % 2;   m_q = m_q / 2 + (m_q % 2) * 128;     end
            default: ;
        endcase
    endtask

    task automatic model_edge();
        int md, n;
        int nd;
        md = int'(mode);
        nd = 0;
        if (en) begin
            if (m_busy != 0) begin
                model_apply(m_op);
                m_cnt--;
                if (m_cnt == 0) begin m_busy = 0; nd = 1; end
            end else if (start && md >= 2 && md <= 5) begin
                m_op = md;
                n = (int'(amt) > WIDTH) ? WIDTH : int'(amt);
                if (n == 0) nd = 1;
                else begin m_busy = 1; m_cnt = n; end
            end else begin
                case (md)
                    1: m_q = int'(d);
                    6: m_q = 0;
                    7: m_q = 255;
                    2, 3, 4, 5: model_apply(md);
                    default: ;
                endcase
            end
        end
        m_done = nd;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic drive(input logic e, input logic [2:0] m, input logic [7:0] dd,
                         input logic s, input logic st, input logic [AW-1:0] a);
        en = e; mode = m; d = dd; sin = s; start = st; amt = a;
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1 model_reset();
        check_model();
        @(posedge clk);
        #1 check_model();
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_q", int'(q), 'hA5);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_sout", int'(sout), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        check_model();

        drive(1, 1, 8'h81, 0, 0, 0); step();
        drive(1, 4, 8'h00, 0, 0, 0); step();
        check("rol_q", int'(q), 'h03);
        check("rol_sout", int'(sout), 1);
        drive(1, 3, 8'h00, 1, 0, 0); step();
        check("shr_q", int'(q), 'h81);
        check("shr_sout", int'(sout), 1);

        drive(1, 1, 8'h0F, 0, 0, 0); step();
        drive(1, 2, 8'h00, 0, 1, 3); step();
        check("bshl_busy0", int'(busy), 1);
        drive(1, 0, 8'h00, 0, 0, 0);
        step(); check("bshl_q1", int'(q), 'h1E);
        step(); check("bshl_q2", int'(q), 'h3C); check("bshl_busy2", int'(busy), 1);
        step(); check("bshl_q3", int'(q), 'h78); check("bshl_done", int'(done), 1);
        check("bshl_sout", int'(sout), 0);
        step(); check("bshl_done_end", int'(done), 0);

        drive(1, 1, 8'h01, 0, 0, 0); step();
        drive(1, 5, 8'h00, 0, 1, 2); step();
        drive(1, 0, 8'h00, 0, 0, 0); step(); check("stall_q1", int'(q), 'h80);
        en = 1'b0; step(); step();
        check("stall_hold", int'(q), 'h80); check("stall_busy", int'(busy), 1);
        en = 1'b1; step();
        check("stall_q2", int'(q), 'h40); check("stall_done", int'(done), 1);
        step(); check("stall_done_end", int'(done), 0);

        drive(1, 2, 8'h00, 1, 1, 0); step();
        check("amt0_busy", int'(busy), 0); check("amt0_done", int'(done), 1);
        check("amt0_q", int'(q), 'h40);
        drive(1, 0, 8'h00, 0, 0, 0); step();

        drive(1, 1, 8'hB4, 0, 0, 0); step();
        drive(1, 4, 8'h00, 0, 1, 15); step();
        drive(1, 0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 8; i++) step();
        check("clamp_q", int'(q), 'hB4); check("clamp_done", int'(done), 1);
        step();

        drive(1, 1, 8'h33, 0, 0, 0); step();
        drive(1, 2, 8'h00, 1, 1, 5); step();
        drive(1, 0, 8'h00, 1, 0, 0); step(); step();
        pulse_reset();
        check("abort_q", int'(q), 'hA5); check("abort_busy", int'(busy), 0);
        for (int i = 0; i < 5; i++) begin
            step(); check("abort_no_done", int'(done), 0);
        end

        drive(1, 1, 8'h11, 0, 0, 0); step();
        drive(1, 3, 8'h00, 0, 1, 2); step();
        drive(1, 6, 8'h00, 0, 0, 0); step(); check("ign_q1", int'(q), 'h08);
        step(); check("ign_q2", int'(q), 'h04); check("ign_done", int'(done), 1);

        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 8) != 0, 3'($urandom), 8'($urandom), 1'($urandom),
                  ($urandom % 3) == 0, 4'($urandom));
            if ($urandom % 200 == 0) pulse_reset();
            else step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal register, the successor to the team's single-bit enable flop and mode-controlled flop. It provides a WIDTH-bit register with enable and a 3-bit operation mode: hold, load, shift, rotate, synchronous clear and synchronous set. It adds a multi-cycle burst engine that applies a shift or rotate a programmed number of times, with busy and done status. It is used as a datapath staging/serialiser register in the example designs.

Parameters:
WIDTH, 8, register width in bits (legal range 2 to 32).
RST_VAL, 0, value loaded into q on asynchronous reset (WIDTH bits).
AW, $clog2(WIDTH+1), width of the burst amount (derived; not to be overridden).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
en  input  1  clock enable; when 0, all state holds, including the burst counter.
mode  input  3  operation select: 0 hold, 1 load, 2 shift-left, 3 shift-right, 4 rotate-left, 5 rotate-right, 6 clear, 7 set.
d  input  WIDTH  parallel load data.
sin  input  1  serial input for shifts (mode 2 enters at LSB; mode 3 enters at MSB).
start  input  1  burst request; valid only with mode 2 to 5.
amt  input  AW  burst shift count, sampled with start.
q  output  WIDTH  register contents.
sout  output  1  registered copy of the bit most recently shifted or rotated out.
busy  output  1  high while a burst is running.
done  output  1  one-cycle pulse on burst completion.

Behaviour:
- Reset, asynchronous and active-high: q=RST_VAL, sout=0, busy=0, done=0, FSM=IDLE, cnt=0. A reset mid-burst aborts the burst and raises no done.
- FSM states: IDLE and RUN. busy = (state==RUN).
- IDLE, en=1, start=0: single-cycle operation on the next edge.
  - Load: q=d.
  - Shift-left: q={q[W-2:0],sin}, sout=q[W-1].
  - Shift-right: q={sin,q[W-1:1]}, sout=q[0].
  - Rotate-left / rotate-right: bit moves end to end; sout = the bit that wrapped.
  - Clear: q=0. Set: q=all ones. Hold: no change.
  - sout updates only on modes 2 to 5.
- IDLE, en=1, start=1, mode in 2 to 5:
  - Latch op=mode and cnt=min(amt,WIDTH).
  - q is unchanged on this edge; next state RUN.
  - If the clamped amt==0: stay IDLE, done=1 next cycle, q unchanged.
- IDLE, start=1 with mode 0, 1, 6 or 7: start is ignored and the mode executes normally.
- RUN, en=1:
  - Each edge applies the latched op once (sin sampled each cycle) and decrements cnt.
  - On the edge where cnt goes 1 to 0: state goes to IDLE and done=1 for exactly the following cycle.
- RUN, en=0: full stall; q, cnt and sout hold; busy stays 1.
- RUN: mode, d, start and amt are ignored. A burst cannot be restarted until busy=0.
- done is registered, high for one cycle, and independent of en on the cycle it is visible.
- Back-to-back: start may be asserted in the cycle done is high, since state is IDLE.
- Latency: a burst of N shifts with en held high gives busy for N cycles and done in cycle N+1 after the start edge.

Decomposition:
- Shared package usr_pkg holds:
  - mode localparams MODE_HOLD..MODE_SET (3-bit) in a typedef enum usr_mode_t;
  - FSM enum usr_state_t {S_IDLE,S_RUN}.
- One sub-module, usr_shift_unit: combinational next-q/next-sout from (q, op, sin). The main module is shared with single-cycle and burst paths by instantiating it once, fed by a mux of mode vs latched op.

Test Plan:
- Reset: RST_VAL=8'hA5, rst pulsed mid-clock-low with no clk edge -> q=8'hA5, busy=0, done=0, sout=0 immediately (asynchronous).
- Load then rotate-left: d=8'h81 with mode 1, then mode 4 for one cycle -> q=8'h03, sout=1. Next, mode 3 with sin=1 -> q=8'h81, sout=1.
- Burst shift-left:
  - Stimulus: q=8'h0F, start with mode 2, amt=3, sin=0, en held 1.
  - Response: busy high 3 cycles; q goes 1E, 3C, 78; done pulses in the 4th cycle; sout ends 0.
- Burst with stall:
  - Stimulus: rotate-right, amt=2 on q=8'h01; en low for 2 cycles between the two shifts.
  - Response: q=8'h80, holds, then 8'h40; busy held through the stall; done exactly once.
- Edge amts:
  - amt=0 -> no busy, done one cycle, q unchanged.
  - amt=15 with WIDTH=8 -> clamped to 8 shifts; rotate returns the original q.
- Abort and ignore:
  - rst asserted during a RUN of amt=5 after 2 shifts -> q=RST_VAL, busy=0, no done afterward.
  - Separately, mode 6 during RUN -> ignored, burst completes normally.
